seg7_count_display: RTL

SEG7_COUNT_DISPLAY -- requirements
Module: seg7_count_display

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 95 +++++++++
 rtl/seg7_count_display.sv | 83 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-bit counter to 3-digit 7-segment display path.
// Holds the converter state encoding, BCD/digit sizing and the segment decode table.
package seg7_pkg;

   localparam int BCD_W  = 12;
   localparam int DIGITS = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_DONE
   } conv_state_t;

   // Active-high {g,f,e,d,c,b,a}; anything that is not a decimal digit shows nothing.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary to 3-digit BCD, one shift per clock.
// The output register only changes in DONE, so downstream logic never sees partial results.
module bin2bcd_seq
   import seg7_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       bin,
   output logic [BCD_W-1:0] bcd,
   output logic             bcd_valid
);

   conv_state_t      r_state;
   conv_state_t      w_state_next;
   logic [6:0]       r_shift;
   logic [6:0]       r_last_bin;
   logic             r_pending;
   logic [BCD_W-1:0] r_scratch;
   logic [2:0]       r_iter;
   logic [BCD_W-1:0] r_bcd;
   logic             r_bcd_valid;
   logic [BCD_W-1:0] w_adj;
   logic             w_start;

   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign w_adj   = dd_adjust(r_scratch);
   // Pending forces one conversion after reset even when the input equals last_bin.
   assign w_start = r_pending || (bin != r_last_bin);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: the default assignment first keeps this block purely combinational (no inferred latch).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_next = ST_CONV;
         ST_CONV: if (r_iter == 3'd7) w_state_next = ST_DONE;
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift     <= '0;
         r_last_bin  <= '0;
         r_pending   <= 1'b1;
         r_scratch   <= '0;
         r_iter      <= '0;
         r_bcd       <= '0;
         r_bcd_valid <= 1'b0;
      end else begin
         r_bcd_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_shift    <= bin;
                  r_last_bin <= bin;
                  r_pending  <= 1'b0;
                  r_scratch  <= '0;
                  r_iter     <= '0;
               end
            end
            ST_CONV: begin
               if (r_iter != 3'd7) begin
                  r_scratch <= {w_adj[BCD_W-2:0], r_shift[6]};
                  r_shift   <= {r_shift[5:0], 1'b0};
                  r_iter    <= r_iter + 3'd1;
               end
            end
            ST_DONE: begin
               r_bcd       <= r_scratch;
               r_bcd_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bcd       = r_bcd;
   assign bcd_valid = r_bcd_valid;

endmodule

// File: rtl/seg7_count_display.sv
// Counter value display: converts count_in to BCD and time-multiplexes three 7-segment digits
// with leading-zero blanking; an and seg are registered together so they always match.
module seg7_count_display
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        count_in,
   output logic [BCD_W-1:0]  bcd,
   output logic              bcd_valid,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? ~seg_decode(4'd0) : seg_decode(4'd0);

   logic [BCD_W-1:0]  w_bcd;
   logic [PW-1:0]     r_presc;
   logic [1:0]        r_digit;
   logic [DIGITS-1:0] r_an;
   logic [6:0]        r_seg;
   logic [3:0]        w_nib;
   logic              w_blank;
   logic [6:0]        w_dec;
   logic [DIGITS-1:0] w_onehot;

   bin2bcd_seq u_conv (
      .clk       (clk),
      .rst       (rst),
      .bin       (count_in),
      .bcd       (w_bcd),
      .bcd_valid (bcd_valid)
   );

   // Digit selection reads only the registered BCD, never the converter scratch.
   always_comb begin
      w_nib    = w_bcd[3:0];
      w_blank  = 1'b0;
      w_onehot = 3'b001;
      case (r_digit)
         2'd1: begin
            w_nib    = w_bcd[7:4];
            w_blank  = (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);
            w_onehot = 3'b010;
         end
         2'd2: begin
            w_nib    = w_bcd[11:8];
            w_blank  = (w_bcd[11:8] == 4'd0);
            w_onehot = 3'b100;
         end
         default: ;
      endcase
      w_dec = w_blank ? 7'h00 : seg_decode(w_nib);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
         r_digit <= 2'd0;
         r_an    <= 3'b001;
         r_seg   <= SEG_RESET;
      end else begin
         if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
         r_an  <= w_onehot;
         r_seg <= SEG_ACTIVE_LOW ? ~w_dec : w_dec;
      end
   end

   assign bcd = w_bcd;
   assign an  = r_an;
   assign seg = r_seg;

endmodule
